// File: rtl/coin_start_seq_pkg.sv
// Shared types and constants for the coin/start input sequencer.
// Optional credit counter is enabled with COIN_START_SEQ_CREDIT_COUNT_EN.
package coin_start_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        START,
        RELEASE
    } seq_state_t;

    localparam int CREDIT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/coin_start_seq_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// clr restarts the count so the next tick is a full TICK_DIV cycles away.
module tick_prescaler #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // tick marks the cycle whose clock edge wraps the count back to 0
    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/coin_start_seq.sv
// Turns a Start 1P/2P press into a timed coin -> gap -> start -> release sequence.
// Defining COIN_START_SEQ_CREDIT_COUNT_EN adds a saturating credit counter on coin_out.
module coin_start_seq
    import coin_start_seq_pkg::*;
#(
    parameter int TICK_DIV    = 12000,
    parameter int COIN_TICKS  = 100,
    parameter int GAP_TICKS   = 200,
    parameter int START_TICKS = 100
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start1_in,
    input  logic start2_in,
    input  logic coin_in,
    output logic coin_out,
    output logic start1_out,
    output logic start2_out,
    output logic busy
`ifdef COIN_START_SEQ_CREDIT_COUNT_EN
    ,
    output logic [CREDIT_W-1:0] credits,
    input  logic                credit_clr
`endif
);

    localparam int MAX_TICKS = max3(COIN_TICKS, GAP_TICKS, START_TICKS);
    localparam int TCW       = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;

    seq_state_t     state_q, state_d;
    logic           sel_q, sel_d;
    logic           prev1_q, prev2_q;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic           coin_seq_q, coin_seq_d;
    logic           start1_q, start1_d;
    logic           start2_q, start2_d;
    logic           busy_q, busy_d;
    logic           rise1, rise2;
    logic           tick;
    logic           clr;

    // A zero-length state still occupies one clock before moving on.
    function automatic logic timed_done(input int ticks, input logic tk,
                                        input logic [TCW-1:0] cnt);
        return (ticks == 0) || (tk && (cnt == TCW'(ticks - 1)));
    endfunction

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk_sys(clk_sys),
        .reset  (reset),
        .clr    (clr),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rise1   = start1_in & ~prev1_q;
        rise2   = start2_in & ~prev2_q;

        unique case (state_q)
            IDLE: begin
                if (rise1 || rise2) begin
                    state_d = COIN;
                    sel_d   = ~rise1;
                end
            end
            COIN: begin
                if (timed_done(COIN_TICKS, tick, tick_cnt_q)) state_d = GAP;
            end
            GAP: begin
                if (timed_done(GAP_TICKS, tick, tick_cnt_q)) state_d = START;
            end
            START: begin
                if (timed_done(START_TICKS, tick, tick_cnt_q)) state_d = RELEASE;
            end
            RELEASE: begin
                if (!(start1_in || start2_in)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the timebase so durations are exact.
        clr = (state_d != state_q);

        tick_cnt_d = tick_cnt_q;
        if (clr) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        coin_seq_d = (state_d == COIN);
        start1_d   = (state_d == START) && !sel_d;
        start2_d   = (state_d == START) && sel_d;
        busy_d     = (state_d != IDLE);
    end

    // prev flops reset high so a button held through reset needs a fresh press.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            prev1_q    <= 1'b1;
            prev2_q    <= 1'b1;
            tick_cnt_q <= '0;
            coin_seq_q <= 1'b0;
            start1_q   <= 1'b0;
            start2_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            prev1_q    <= start1_in;
            prev2_q    <= start2_in;
            tick_cnt_q <= tick_cnt_d;
            coin_seq_q <= coin_seq_d;
            start1_q   <= start1_d;
            start2_q   <= start2_d;
            busy_q     <= busy_d;
        end
    end

    assign coin_out   = coin_seq_q | coin_in;
    assign start1_out = start1_q;
    assign start2_out = start2_q;
    assign busy       = busy_q;

`ifdef COIN_START_SEQ_CREDIT_COUNT_EN
    logic                coin_prev_q;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                coin_rise;

    always_comb begin
        coin_rise = coin_out & ~coin_prev_q;
        credits_d = credits_q;
        if (credit_clr) begin
            credits_d = '0;
        end else if (coin_rise && (credits_q != {CREDIT_W{1'b1}})) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            coin_prev_q <= 1'b0;
            credits_q   <= '0;
        end else begin
            coin_prev_q <= coin_out;
            credits_q   <= credits_d;
        end
    end

    assign credits = credits_q;
`endif

endmodule

// File: tb/tb_coin_start_seq.sv
// Directed bench for coin_start_seq with a shortened timebase.
// Credit counter scenario is built when COIN_START_SEQ_CREDIT_COUNT_EN is defined.
module tb_coin_start_seq;
    import coin_start_seq_pkg::*;

    logic clk_sys   = 1'b0;
    logic reset     = 1'b1;
    logic start1_in = 1'b0;
    logic start2_in = 1'b0;
    logic coin_in   = 1'b0;
    logic coin_out;
    logic start1_out;
    logic start2_out;
    logic busy;
`ifdef COIN_START_SEQ_CREDIT_COUNT_EN
    logic [CREDIT_W-1:0] credits;
    logic                credit_clr = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    coin_start_seq #(
        .TICK_DIV   (4),
        .COIN_TICKS (3),
        .GAP_TICKS  (2),
        .START_TICKS(3)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start1_in (start1_in),
        .start2_in (start2_in),
        .coin_in   (coin_in),
        .coin_out  (coin_out),
        .start1_out(start1_out),
        .start2_out(start2_out),
        .busy      (busy)
`ifdef COIN_START_SEQ_CREDIT_COUNT_EN
        ,
        .credits   (credits),
        .credit_clr(credit_clr)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    int s1_hi, s2_hi, coin_rises;
    logic coin_prev;

    initial begin
        // Reset state
        tick();
        check_eq("rst_coin", 32'(coin_out), 0);
        check_eq("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();
        check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rst_start1", 32'(start1_out), 0);
        check_eq("rst_start2", 32'(start2_out), 0);

        // Basic sequence: 1-clk pulse on start1
        start1_in = 1'b1;
        tick();
        start1_in = 1'b0;
        for (int i = 0; i < 34; i++) begin
            check_eq($sformatf("basic_coin[%0d]", i), 32'(coin_out), 32'(i < 12));
            check_eq($sformatf("basic_s1[%0d]", i), 32'(start1_out),
                     32'((i >= 20) && (i < 32)));
            check_eq($sformatf("basic_s2[%0d]", i), 32'(start2_out), 0);
            check_eq($sformatf("basic_busy[%0d]", i), 32'(busy), 32'(i < 33));
            tick();
        end

        // Simultaneous rise: start1 wins
        start1_in = 1'b1;
        start2_in = 1'b1;
        tick();
        start1_in = 1'b0;
        start2_in = 1'b0;
        s1_hi = 0;
        s2_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (start1_out) s1_hi++;
            if (start2_out) s2_hi++;
            tick();
        end
        check_eq("simul_s1_cycles", 32'(s1_hi), 12);
        check_eq("simul_s2_cycles", 32'(s2_hi), 0);
        check_eq("simul_busy_end", 32'(busy), 0);

        // Held start2 for 60 clocks from the rise
        start2_in = 1'b1;
        tick();
        s1_hi = 0;
        s2_hi = 0;
        coin_rises = 0;
        coin_prev = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (coin_out && !coin_prev) coin_rises++;
            coin_prev = coin_out;
            if (start1_out) s1_hi++;
            if (start2_out) s2_hi++;
            if (i == 45) check_eq("held_state_release", 32'(dut.state_q), 32'(RELEASE));
            if (i == 59 || i == 60)
                check_eq($sformatf("held_busy[%0d]", i), 32'(busy), 32'(i < 60));
            if (i == 59) start2_in = 1'b0;
            tick();
        end
        check_eq("held_coin_rises", 32'(coin_rises), 1);
        check_eq("held_s2_cycles", 32'(s2_hi), 12);
        check_eq("held_s1_cycles", 32'(s1_hi), 0);

        // Press during GAP is discarded
        start1_in = 1'b1;
        tick();
        start1_in = 1'b0;
        s1_hi = 0;
        coin_rises = 0;
        coin_prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (coin_out && !coin_prev) coin_rises++;
            coin_prev = coin_out;
            if (start1_out) s1_hi++;
            if (i == 14) begin
                check_eq("ign_in_gap", 32'(dut.state_q), 32'(GAP));
                start1_in = 1'b1;
            end
            if (i == 15) start1_in = 1'b0;
            tick();
        end
        check_eq("ign_coin_rises", 32'(coin_rises), 1);
        check_eq("ign_s1_cycles", 32'(s1_hi), 12);
        check_eq("ign_busy_end", 32'(busy), 0);

        // Reset mid-COIN with start1 held through reset release
        start1_in = 1'b1;
        tick();
        tick();
        tick();
        check_eq("midrst_coin_before", 32'(coin_out), 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_coin_now", 32'(coin_out), 0);
        check_eq("midrst_busy_now", 32'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check_eq("midrst_state_idle", 32'(dut.state_q), 32'(IDLE));
        check_eq("midrst_held_no_trig", 32'(busy), 0);
        start1_in = 1'b0;
        tick();
        start1_in = 1'b1;
        tick();
        check_eq("midrst_fresh_busy", 32'(busy), 1);
        check_eq("midrst_fresh_coin", 32'(coin_out), 1);
        start1_in = 1'b0;
        do_reset();

        // coin_in passes straight through while idle
        coin_in = 1'b1;
        #1;
        check_eq("coin_pass_hi", 32'(coin_out), 1);
        check_eq("coin_pass_busy", 32'(busy), 0);
        coin_in = 1'b0;
        #1;
        check_eq("coin_pass_lo", 32'(coin_out), 0);
        do_reset();

`ifdef COIN_START_SEQ_CREDIT_COUNT_EN
        check_eq("cred_reset", 32'(credits), 0);
        for (int i = 0; i < 3; i++) begin
            coin_in = 1'b1;
            tick();
            coin_in = 1'b0;
            tick();
        end
        check_eq("cred_three", 32'(credits), 3);
        for (int i = 0; i < 260; i++) begin
            coin_in = 1'b1;
            tick();
            coin_in = 1'b0;
            tick();
        end
        check_eq("cred_saturate", 32'(credits), 255);
        coin_in    = 1'b1;
        credit_clr = 1'b1;
        tick();
        coin_in    = 1'b0;
        credit_clr = 1'b0;
        check_eq("cred_clr_wins", 32'(credits), 0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
